// File: rtl/sa2x2_ctrl_pkg.sv
// sa_pkg: FSM states, array geometry and element packing shared by the sa2x2 controller files.
// Latency: n/a (types, constants and a pure helper function).
// Backpressure: n/a.
package sa_pkg;

    localparam int ARR_DIM  = 2;
    localparam int FEED_CYC = 2 * ARR_DIM - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // Flat element index of (row i, col j) in a packed 2x2 matrix bus.
    function automatic int elem_idx(input int i, input int j);
        return ARR_DIM * i + j;
    endfunction

endpackage

// File: rtl/sa2x2_ctrl_if.sv
// sa2x2_ctrl_if: host-side operands/results plus array-side feeds/accumulators of the sa2x2 controller.
// Latency: n/a (wiring only); job_cnt/stall_cnt exist only when SA2X2_CTRL_PERF_EN is defined.
// Backpressure: none; start is a request that the controller ignores while busy.
interface sa2x2_ctrl_if #(
    parameter int DATA_W = 8
);
    logic                start;
    logic [4*DATA_W-1:0] a_mat;
    logic [4*DATA_W-1:0] b_mat;
    logic [4*DATA_W-1:0] arr_c;
    logic                busy;
    logic                done;
    logic                arr_clr_n;
    logic [DATA_W-1:0]   feed_a0;
    logic [DATA_W-1:0]   feed_a1;
    logic [DATA_W-1:0]   feed_b0;
    logic [DATA_W-1:0]   feed_b1;
    logic [4*DATA_W-1:0] c_mat;
`ifdef SA2X2_CTRL_PERF_EN
    logic [15:0]         job_cnt;
    logic [15:0]         stall_cnt;

    modport master (
        output start, a_mat, b_mat, arr_c,
        input  busy, done, arr_clr_n, feed_a0, feed_a1, feed_b0, feed_b1, c_mat,
        input  job_cnt, stall_cnt
    );
    modport slave (
        input  start, a_mat, b_mat, arr_c,
        output busy, done, arr_clr_n, feed_a0, feed_a1, feed_b0, feed_b1, c_mat,
        output job_cnt, stall_cnt
    );
`else
    modport master (
        output start, a_mat, b_mat, arr_c,
        input  busy, done, arr_clr_n, feed_a0, feed_a1, feed_b0, feed_b1, c_mat
    );
    modport slave (
        input  start, a_mat, b_mat, arr_c,
        output busy, done, arr_clr_n, feed_a0, feed_a1, feed_b0, feed_b1, c_mat
    );
`endif
endinterface

// File: rtl/sa2x2_skew.sv
// sa2x2_skew: maps feed step k and latched A/B onto the skewed row/column edge inputs of the array.
// Latency: combinational; the controller registers the result.
// Backpressure: none; outputs are zero whenever feed_en is low.
module sa2x2_skew
    import sa_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                feed_en,
    input  logic [1:0]          k,
    input  logic [4*DATA_W-1:0] a_lat,
    input  logic [4*DATA_W-1:0] b_lat,
    output logic [DATA_W-1:0]   feed_a0,
    output logic [DATA_W-1:0]   feed_a1,
    output logic [DATA_W-1:0]   feed_b0,
    output logic [DATA_W-1:0]   feed_b1
);

    function automatic logic [DATA_W-1:0] el(input logic [4*DATA_W-1:0] m, input int i, input int j);
        return m[elem_idx(i, j)*DATA_W +: DATA_W];
    endfunction

    // Row 1 / column 1 run one step behind row 0 / column 0 so operands meet in the right PE.
    always_comb begin
        feed_a0 = '0;
        feed_a1 = '0;
        feed_b0 = '0;
        feed_b1 = '0;
        if (feed_en) begin
            case (k)
                2'd0: begin
                    feed_a0 = el(a_lat, 0, 0);
                    feed_b0 = el(b_lat, 0, 0);
                end
                2'd1: begin
                    feed_a0 = el(a_lat, 0, 1);
                    feed_a1 = el(a_lat, 1, 0);
                    feed_b0 = el(b_lat, 1, 0);
                    feed_b1 = el(b_lat, 0, 1);
                end
                2'd2: begin
                    feed_a1 = el(a_lat, 1, 1);
                    feed_b1 = el(b_lat, 1, 1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sa2x2_ctrl.sv
// sa2x2_ctrl: sequences clear/feed/drain/capture for a 2x2 output-stationary MAC array (perf counters: SA2X2_CTRL_PERF_EN).
// Latency: start sampled at edge 0, c_mat loaded at edge 1+3+DRAIN_CYC, done high the following cycle.
// Backpressure: start accepted only in IDLE or DONE; requests while busy are dropped, not queued.
module sa2x2_ctrl
    import sa_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    sa2x2_ctrl_if.slave bus
);

    localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

    state_t              state, state_nxt;
    logic [1:0]          k, k_nxt;
    logic [DCNT_W-1:0]   dcnt, dcnt_nxt;
    logic                load_op;
    logic                capture;
    logic [4*DATA_W-1:0] a_lat, b_lat;
    logic [DATA_W-1:0]   skew_a0, skew_a1, skew_b0, skew_b1;

    logic                busy_q, done_q, clr_n_q;
    logic [DATA_W-1:0]   fa0_q, fa1_q, fb0_q, fb1_q;
    logic [4*DATA_W-1:0] c_q;

    // Next-state decode; operands are latched on the edge that accepts start.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        dcnt_nxt  = dcnt;
        load_op   = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_CLEAR;
                    load_op   = 1'b1;
                end
            end
            S_CLEAR: begin
                state_nxt = S_FEED;
                k_nxt     = '0;
            end
            S_FEED: begin
                if (k == 2'(FEED_CYC - 1)) begin
                    state_nxt = S_DRAIN;
                    dcnt_nxt  = '0;
                end else begin
                    k_nxt = k + 2'd1;
                end
            end
            S_DRAIN: begin
                if (dcnt == DCNT_W'(DRAIN_CYC - 1)) begin
                    state_nxt = S_DONE;
                    capture   = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_nxt = S_CLEAR;
                    load_op   = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, step counters and operand latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            k     <= '0;
            dcnt  <= '0;
            a_lat <= '0;
            b_lat <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            dcnt  <= dcnt_nxt;
            if (load_op) begin
                a_lat <= bus.a_mat;
                b_lat <= bus.b_mat;
            end
        end
    end

    sa2x2_skew #(.DATA_W(DATA_W)) u_skew (
        .feed_en (state_nxt == S_FEED),
        .k       (k_nxt),
        .a_lat   (a_lat),
        .b_lat   (b_lat),
        .feed_a0 (skew_a0),
        .feed_a1 (skew_a1),
        .feed_b0 (skew_b0),
        .feed_b1 (skew_b1)
    );

    // Outputs are registered from the upcoming state so each one lines up with the state it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_n_q <= 1'b0;
            fa0_q   <= '0;
            fa1_q   <= '0;
            fb0_q   <= '0;
            fb1_q   <= '0;
            c_q     <= '0;
        end else begin
            busy_q  <= state_nxt inside {S_CLEAR, S_FEED, S_DRAIN};
            done_q  <= (state_nxt == S_DONE);
            clr_n_q <= (state_nxt != S_CLEAR);
            fa0_q   <= skew_a0;
            fa1_q   <= skew_a1;
            fb0_q   <= skew_b0;
            fb1_q   <= skew_b1;
            if (capture) begin
                c_q <= bus.arr_c;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.arr_clr_n = clr_n_q;
    assign bus.feed_a0   = fa0_q;
    assign bus.feed_a1   = fa1_q;
    assign bus.feed_b0   = fb0_q;
    assign bus.feed_b1   = fb1_q;
    assign bus.c_mat     = c_q;

`ifdef SA2X2_CTRL_PERF_EN
    logic [15:0] job_cnt_q, stall_cnt_q;

    // Jobs count on the capture edge (one per done pulse); stalls count start requests seen while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            job_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture) begin
                job_cnt_q <= job_cnt_q + 16'd1;
            end
            if (bus.start && busy_q && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.job_cnt   = job_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sa2x2_ctrl.sv
// tb_sa2x2_ctrl: drives sa2x2_ctrl against a behavioural 2x2 MAC array and checks results against a matrix-product model.
// Latency: expects c_mat/done 1+3+DRAIN cycles after the start-sampling edge.
// Backpressure: exercises start held or pulsed while busy (ignored) and start held through DONE (back-to-back).
module tb_sa2x2_ctrl;

    localparam int DW       = 8;
    localparam int DRAIN    = 2;
    localparam int LAT      = 1 + 3 + DRAIN;   // sampling edge to done
    localparam int BUSY_CYC = 1 + 3 + DRAIN;   // CLEAR + FEED + DRAIN cycles

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    sa2x2_ctrl_if #(.DATA_W(DW)) bus ();

    sa2x2_ctrl #(.DATA_W(DW), .DRAIN_CYC(DRAIN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural output-stationary array: PE p = 2i+j, A flows right, B flows down.
    logic [DW-1:0] acc    [4];
    logic [DW-1:0] a_pass [4];
    logic [DW-1:0] b_pass [4];

    function automatic logic [DW-1:0] a_in(input int i, input int j);
        if (j == 0) return (i == 0) ? bus.feed_a0 : bus.feed_a1;
        return a_pass[2*i + j - 1];
    endfunction

    function automatic logic [DW-1:0] b_in(input int i, input int j);
        if (i == 0) return (j == 0) ? bus.feed_b0 : bus.feed_b1;
        return b_pass[j];
    endfunction

    initial begin
        for (int p = 0; p < 4; p++) begin
            acc[p] = '0; a_pass[p] = '0; b_pass[p] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (!bus.arr_clr_n) begin
                    acc[2*i+j]    <= '0;
                    a_pass[2*i+j] <= '0;
                    b_pass[2*i+j] <= '0;
                end else begin
                    acc[2*i+j]    <= acc[2*i+j] + a_in(i, j) * b_in(i, j);
                    a_pass[2*i+j] <= a_in(i, j);
                    b_pass[2*i+j] <= b_in(i, j);
                end
            end
        end
    end

    assign bus.arr_c = {acc[3], acc[2], acc[1], acc[0]};

    // Reference: C = A*B mod 2^DW with plain integer arithmetic.
    function automatic logic [4*DW-1:0] matmul(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
        logic [4*DW-1:0] c;
        int s;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int m = 0; m < 2; m++) begin
                    s += int'(a[(2*i+m)*DW +: DW]) * int'(b[(2*m+j)*DW +: DW]);
                end
                c[(2*i+j)*DW +: DW] = DW'(s % (1 << DW));
            end
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Per-cycle samples of the last job, index = edges after the start-sampling edge.
    int          lat, busy_n, clr_low;
    logic [31:0] s_feed [16];
    logic        s_clr  [16];

    task automatic sample(input int cyc);
        if (bus.busy) busy_n++;
        if (!bus.arr_clr_n) clr_low++;
        if (cyc < 16) begin
            s_feed[cyc] = {bus.feed_a0, bus.feed_a1, bus.feed_b0, bus.feed_b1};
            s_clr[cyc]  = bus.arr_clr_n;
        end
    endtask

    task automatic run_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input int stalls);
        int cyc;
        bus.a_mat = a; bus.b_mat = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a_mat = $urandom; bus.b_mat = $urandom;   // latched already; scramble to prove it
        cyc = 0; busy_n = 0; clr_low = 0;
        sample(0);
        while (!bus.done && cyc < 40) begin
            bus.start = (cyc >= 1 && cyc < 1 + stalls);
            @(posedge clk); #1;
            cyc++;
            sample(cyc);
        end
        bus.start = 1'b0;
        lat = cyc;
    endtask

    task automatic job_checks(input string name, input logic [4*DW-1:0] exp_c);
        chk({name, "_lat"},  lat,       LAT);
        chk({name, "_busy"}, busy_n,    BUSY_CYC);
        chk({name, "_c"},    bus.c_mat, exp_c);
        @(posedge clk); #1;
        chk({name, "_done1"}, {31'd0, bus.done}, 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] exp_feed [5];
    logic [31:0] ra, rb;
    int          gap;
    logic        done_seen;

    initial begin
        // {A11,A10,A01,A00} packing; expected C derived by hand.
        vecs[0] = '{"basic", 32'h04030201, 32'h08070605, 32'h322B1613};   // [[19,22],[43,50]]
        vecs[1] = '{"wrap",  32'h01001010, 32'h01100010, 32'h01101000};   // [[0,16],[16,1]]
        vecs[2] = '{"ident", 32'h01000001, 32'h06070809, 32'h06070809};
        vecs[3] = '{"allff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h02020202};   // 2*255*255 mod 256
        // {feed_a0, feed_a1, feed_b0, feed_b1} for CLEAR, FEED k=0..2, first DRAIN cycle
        exp_feed[0] = 32'h00000000;
        exp_feed[1] = 32'h01000500;
        exp_feed[2] = 32'h02030706;
        exp_feed[3] = 32'h00040008;
        exp_feed[4] = 32'h00000000;

        bus.start = 1'b0; bus.a_mat = '0; bus.b_mat = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, bus.busy},      32'd0);
        chk("rst_done",  {31'd0, bus.done},      32'd0);
        chk("rst_clr_n", {31'd0, bus.arr_clr_n}, 32'd0);
        chk("rst_feeds", {bus.feed_a0, bus.feed_a1, bus.feed_b0, bus.feed_b1}, 32'd0);
        chk("rst_c",     bus.c_mat,              32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_clr_n", {31'd0, bus.arr_clr_n}, 32'd1);

        // Table vectors, each also cross-checked against the reference product.
        for (int t = 0; t < 4; t++) begin
            chk({vecs[t].name, "_model"}, matmul(vecs[t].a, vecs[t].b), vecs[t].c);
            run_job(vecs[t].a, vecs[t].b, 0);
            job_checks(vecs[t].name, vecs[t].c);
        end

        // Feed skew and clear pulse on the basic operands.
        run_job(vecs[0].a, vecs[0].b, 0);
        for (int c = 0; c < 5; c++) chk($sformatf("skew_%0d", c), s_feed[c], exp_feed[c]);
        chk("clr_cycles", clr_low, 1);
        chk("clr_pos", {31'd0, s_clr[0]}, 32'd0);
        job_checks("skewjob", vecs[0].c);

        // Back-to-back: start held through busy and DONE; second operands presented mid-job.
        bus.a_mat = vecs[0].a; bus.b_mat = vecs[0].b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a_mat = vecs[2].a; bus.b_mat = vecs[2].b;
        gap = 0;
        while (!bus.done && gap < 40) begin @(posedge clk); #1; gap++; end
        chk("b2b_lat1", gap, LAT);
        chk("b2b_c1", bus.c_mat, vecs[0].c);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_restart", {31'd0, bus.busy}, 32'd1);
        gap = 1;
        while (!bus.done && gap < 40) begin @(posedge clk); #1; gap++; end
        chk("b2b_gap", gap, LAT + 1);
        chk("b2b_c2", bus.c_mat, vecs[2].c);
        @(posedge clk); #1;

        // Reset during FEED k=1.
        bus.a_mat = vecs[0].a; bus.b_mat = vecs[0].b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_feed_k1", {bus.feed_a0, bus.feed_a1, bus.feed_b0, bus.feed_b1}, exp_feed[2]);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
        chk("mid_rst_done",  {31'd0, bus.done},      32'd0);
        chk("mid_rst_clr_n", {31'd0, bus.arr_clr_n}, 32'd0);
        chk("mid_rst_feeds", {bus.feed_a0, bus.feed_a1, bus.feed_b0, bus.feed_b1}, 32'd0);
        chk("mid_rst_c",     bus.c_mat,              32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (bus.done) done_seen = 1'b1; end
        chk("mid_rst_nodone", {31'd0, done_seen}, 32'd0);
        run_job(vecs[1].a, vecs[1].b, 0);
        job_checks("post_rst", vecs[1].c);

        // Random operands, with random start pulses while busy.
        for (int r = 0; r < 12; r++) begin
            ra = $urandom; rb = $urandom;
            run_job(ra, rb, $urandom_range(0, 4));
            job_checks($sformatf("rnd%0d", r), matmul(ra, rb));
        end

`ifdef SA2X2_CTRL_PERF_EN
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("perf_rst_jobs",   {16'd0, bus.job_cnt},   32'd0);
        chk("perf_rst_stalls", {16'd0, bus.stall_cnt}, 32'd0);
        run_job(vecs[0].a, vecs[0].b, 0);
        job_checks("perf_j1", vecs[0].c);
        run_job(vecs[1].a, vecs[1].b, 4);
        job_checks("perf_j2", vecs[1].c);
        run_job(vecs[2].a, vecs[2].b, 0);
        job_checks("perf_j3", vecs[2].c);
        chk("perf_jobs",   {16'd0, bus.job_cnt},   32'd3);
        chk("perf_stalls", {16'd0, bus.stall_cnt}, 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
